// File: rtl/taxi_eth_port_led_pkg.sv
// taxi_eth_port_led_pkg
//
// Shared types and helpers for the Ethernet cage LED / link-status controller.
//   port_state_t  : per-port link state (ABSENT, NO_LINK, PARTIAL, LINK_UP)
//   colour_t      : status colour index, also the lamp-test step order R->G->B->Y
//   ms_to_cycles  : converts a millisecond count into clk cycles
//   colour_onehot : maps a colour index onto the {y, b, g, r} LED vector

package taxi_eth_port_led_pkg;

  typedef enum logic [1:0] {
    PORT_ABSENT  = 2'd0,
    PORT_NO_LINK = 2'd1,
    PORT_PARTIAL = 2'd2,
    PORT_LINK_UP = 2'd3
  } port_state_t;

  typedef enum logic [1:0] {
    COLOUR_R = 2'd0,
    COLOUR_G = 2'd1,
    COLOUR_B = 2'd2,
    COLOUR_Y = 2'd3
  } colour_t;

  function automatic int ms_to_cycles(input int clk_freq_hz, input int ms);
    return (clk_freq_hz / 1000) * ms;
  endfunction

  // Bit order of the returned vector is {y, b, g, r}.
  function automatic logic [3:0] colour_onehot(input colour_t c);
    logic [3:0] v;
    v = 4'b0000;
    case (c)
      COLOUR_R: v = 4'b0001;
      COLOUR_G: v = 4'b0010;
      COLOUR_B: v = 4'b0100;
      COLOUR_Y: v = 4'b1000;
      default:  v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/taxi_eth_port_led_port.sv
// taxi_eth_port_led_port
//
// One cage worth of LED logic: lane-status debounce, port state machine,
// activity stretch counter and the colour map. The ms tick, blink phase and
// lamp-test step are generated once in the top and shared by every port.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   tick            : single-cycle 1 ms strobe
//   blink_phase     : global blink phase (1 = on half)
//   lamp_test       : lamp test enable
//   lamp_step       : current lamp-test colour index (colour_t encoding)
//   lane_rx_status  : this port's lane link-up levels
//   lane_act        : this port's lane activity pulses
//   present         : module present
//   link_up         : registered (state == LINK_UP)
//   led_act         : registered activity LED, polarity applied
//   led_r/g/b/y     : registered status colour LEDs, polarity applied

module taxi_eth_port_led_port
  import taxi_eth_port_led_pkg::*;
#(
  parameter int   LANE_CNT       = 4,
  parameter int   ACT_STRETCH_MS = 30,
  parameter int   DEBOUNCE_MS    = 10,
  parameter logic LED_ACT_LOW    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                blink_phase,
  input  logic                lamp_test,
  input  logic [1:0]          lamp_step,
  input  logic [LANE_CNT-1:0] lane_rx_status,
  input  logic [LANE_CNT-1:0] lane_act,
  input  logic                present,
  output logic                link_up,
  output logic                led_act,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b,
  output logic                led_y
);

  localparam int DB_W  = $clog2(DEBOUNCE_MS + 1);
  localparam int ACT_W = $clog2(ACT_STRETCH_MS + 1);

  logic [LANE_CNT-1:0] status_prev;
  logic [DB_W-1:0]     db_cnt;
  logic                debounced;
  port_state_t         state;
  port_state_t         state_nxt;
  logic [ACT_W-1:0]    stretch;
  logic                raw_act;
  logic [3:0]          raw_colour;

  // Debounce: any change in the lane vector restarts the stability window;
  // otherwise count ms ticks and saturate once the vector has been stable long
  // enough. The FSM only acts on lane status while saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_prev <= '0;
      db_cnt      <= '0;
    end else begin
      status_prev <= lane_rx_status;
      if (lane_rx_status != status_prev) begin
        db_cnt <= '0;
      end else if (tick && (db_cnt != DB_W'(DEBOUNCE_MS))) begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign debounced = (db_cnt == DB_W'(DEBOUNCE_MS));

  // Port state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PORT_ABSENT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: module removal overrides everything without debounce; an
  // inserted module always passes through NO_LINK before lane status counts.
  // The classification uses the sampled (stable) vector, not the raw pins.
  always_comb begin
    state_nxt = state;
    if (!present) begin
      state_nxt = PORT_ABSENT;
    end else if (state == PORT_ABSENT) begin
      state_nxt = PORT_NO_LINK;
    end else if (debounced) begin
      if (&status_prev) begin
        state_nxt = PORT_LINK_UP;
      end else if (|status_prev) begin
        state_nxt = PORT_PARTIAL;
      end else begin
        state_nxt = PORT_NO_LINK;
      end
    end
  end

  // Activity stretch: a pulse on any lane reloads the hold time, and the
  // reload takes priority over a decrement landing on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stretch <= '0;
    end else if (|lane_act) begin
      stretch <= ACT_W'(ACT_STRETCH_MS);
    end else if (tick && (stretch != '0)) begin
      stretch <= stretch - ACT_W'(1);
    end
  end

  // Unregistered LED values; raw_colour is {y, b, g, r}. Lamp test only
  // changes what is shown, never the state machine behind it.
  always_comb begin
    raw_act    = 1'b0;
    raw_colour = 4'b0000;
    if (lamp_test) begin
      raw_act    = blink_phase;
      raw_colour = colour_onehot(colour_t'(lamp_step));
    end else begin
      if (stretch != '0) begin
        raw_act = blink_phase;
      end else begin
        raw_act = (state == PORT_LINK_UP);
      end
      case (state)
        PORT_NO_LINK: raw_colour = {blink_phase, 3'b000};
        PORT_PARTIAL: raw_colour = 4'b1000;
        PORT_LINK_UP: raw_colour = 4'b0010;
        default:      raw_colour = 4'b0000;
      endcase
    end
  end

  // Output registers; LED polarity is folded in here so reset lands on the
  // inactive level for either polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_up <= 1'b0;
      led_act <= LED_ACT_LOW;
      led_r   <= LED_ACT_LOW;
      led_g   <= LED_ACT_LOW;
      led_b   <= LED_ACT_LOW;
      led_y   <= LED_ACT_LOW;
    end else begin
      link_up <= (state == PORT_LINK_UP);
      led_act <= raw_act ^ LED_ACT_LOW;
      led_r   <= raw_colour[0] ^ LED_ACT_LOW;
      led_g   <= raw_colour[1] ^ LED_ACT_LOW;
      led_b   <= raw_colour[2] ^ LED_ACT_LOW;
      led_y   <= raw_colour[3] ^ LED_ACT_LOW;
    end
  end

endmodule

// File: rtl/taxi_eth_port_led_ctrl.sv
// taxi_eth_port_led_ctrl
//
// Per-port LED and link-status controller for multi-lane Ethernet cages.
// Generates the shared ms tick, blink phase and lamp-test colour step, and
// instantiates one taxi_eth_port_led_port per cage.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   lane_rx_status    : per-lane link-up levels, lane = port*LANE_CNT + lane
//   lane_act          : per-lane single-cycle activity pulses
//   port_present      : per-port module present
//   cfg_lamp_test     : lamp test enable
//   port_link_up      : per-port debounced all-lanes-up
//   port_led_act      : per-port activity LED
//   port_led_stat_*   : per-port status colour LEDs (r, g, b, y)

module taxi_eth_port_led_ctrl
  import taxi_eth_port_led_pkg::*;
#(
  parameter int   PORT_CNT        = 2,
  parameter int   LANE_CNT        = 4,
  parameter int   CLK_FREQ_HZ     = 125000000,
  parameter int   ACT_STRETCH_MS  = 30,
  parameter int   BLINK_PERIOD_MS = 250,
  parameter int   DEBOUNCE_MS     = 10,
  parameter logic LED_ACT_LOW     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORT_CNT*LANE_CNT-1:0] lane_rx_status,
  input  logic [PORT_CNT*LANE_CNT-1:0] lane_act,
  input  logic [PORT_CNT-1:0]          port_present,
  input  logic                         cfg_lamp_test,
  output logic [PORT_CNT-1:0]          port_link_up,
  output logic [PORT_CNT-1:0]          port_led_act,
  output logic [PORT_CNT-1:0]          port_led_stat_r,
  output logic [PORT_CNT-1:0]          port_led_stat_g,
  output logic [PORT_CNT-1:0]          port_led_stat_b,
  output logic [PORT_CNT-1:0]          port_led_stat_y
);

  localparam int TICK_CYC = ms_to_cycles(CLK_FREQ_HZ, 1);
  localparam int TICK_W   = $clog2(TICK_CYC + 1);
  localparam int HALF_MS  = BLINK_PERIOD_MS / 2;
  localparam int HALF_W   = $clog2(HALF_MS + 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [HALF_W-1:0] phase_cnt;
  logic              blink_phase;
  logic [HALF_W-1:0] lamp_cnt;
  colour_t           lamp_step;

  assign tick = (tick_cnt == TICK_W'(TICK_CYC - 1));

  // ms prescaler; the tick is the last count before the wrap.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Blink phase starts in the on half and flips every half period of ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (tick) begin
      if (phase_cnt == HALF_W'(HALF_MS - 1)) begin
        phase_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        phase_cnt <= phase_cnt + HALF_W'(1);
      end
    end
  end

  // Lamp-test step. Held at R while lamp test is off, so every assertion
  // starts from R with a fresh half-period timer.
  always_ff @(posedge clk) begin
    if (rst || !cfg_lamp_test) begin
      lamp_cnt  <= '0;
      lamp_step <= COLOUR_R;
    end else if (tick) begin
      if (lamp_cnt == HALF_W'(HALF_MS - 1)) begin
        lamp_cnt  <= '0;
        lamp_step <= colour_t'(lamp_step + 2'd1);
      end else begin
        lamp_cnt <= lamp_cnt + HALF_W'(1);
      end
    end
  end

  for (genvar p = 0; p < PORT_CNT; p++) begin : g_port
    taxi_eth_port_led_port #(
      .LANE_CNT       (LANE_CNT),
      .ACT_STRETCH_MS (ACT_STRETCH_MS),
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .LED_ACT_LOW    (LED_ACT_LOW)
    ) u_port (
      .clk            (clk),
      .rst            (rst),
      .tick           (tick),
      .blink_phase    (blink_phase),
      .lamp_test      (cfg_lamp_test),
      .lamp_step      (lamp_step),
      .lane_rx_status (lane_rx_status[p*LANE_CNT +: LANE_CNT]),
      .lane_act       (lane_act[p*LANE_CNT +: LANE_CNT]),
      .present        (port_present[p]),
      .link_up        (port_link_up[p]),
      .led_act        (port_led_act[p]),
      .led_r          (port_led_stat_r[p]),
      .led_g          (port_led_stat_g[p]),
      .led_b          (port_led_stat_b[p]),
      .led_y          (port_led_stat_y[p])
    );
  end

endmodule

// File: tb/tb_taxi_eth_port_led_ctrl.sv
// tb_taxi_eth_port_led_ctrl
//
// Drives two controllers (active-high and active-low LEDs) from the same
// stimulus and compares both against a timestamp-based reference model:
// the model counts elapsed ms ticks and derives blink phase, debounce age,
// activity hold and lamp-test step from tick timestamps of the last event.

module tb_taxi_eth_port_led_ctrl;

  localparam int PC       = 2;
  localparam int LC       = 4;
  localparam int TICK_CYC = 8;
  localparam int ACT_MS   = 3;
  localparam int HALF     = 2;
  localparam int DEB_MS   = 2;

  localparam int M_ABSENT  = 0;
  localparam int M_NO_LINK = 1;
  localparam int M_PARTIAL = 2;
  localparam int M_LINK_UP = 3;

  logic clk = 1'b0;
  logic rst;
  logic [PC*LC-1:0] lane_rx_status;
  logic [PC*LC-1:0] lane_act;
  logic [PC-1:0]    port_present;
  logic             cfg_lamp_test;

  logic [PC-1:0] hi_link, hi_act, hi_r, hi_g, hi_b, hi_y;
  logic [PC-1:0] lo_link, lo_act, lo_r, lo_g, lo_b, lo_y;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  taxi_eth_port_led_ctrl #(
    .PORT_CNT(PC), .LANE_CNT(LC), .CLK_FREQ_HZ(8000), .ACT_STRETCH_MS(ACT_MS),
    .BLINK_PERIOD_MS(2*HALF), .DEBOUNCE_MS(DEB_MS), .LED_ACT_LOW(1'b0)
  ) dut_hi (
    .clk(clk), .rst(rst), .lane_rx_status(lane_rx_status), .lane_act(lane_act),
    .port_present(port_present), .cfg_lamp_test(cfg_lamp_test),
    .port_link_up(hi_link), .port_led_act(hi_act),
    .port_led_stat_r(hi_r), .port_led_stat_g(hi_g),
    .port_led_stat_b(hi_b), .port_led_stat_y(hi_y)
  );

  taxi_eth_port_led_ctrl #(
    .PORT_CNT(PC), .LANE_CNT(LC), .CLK_FREQ_HZ(8000), .ACT_STRETCH_MS(ACT_MS),
    .BLINK_PERIOD_MS(2*HALF), .DEBOUNCE_MS(DEB_MS), .LED_ACT_LOW(1'b1)
  ) dut_lo (
    .clk(clk), .rst(rst), .lane_rx_status(lane_rx_status), .lane_act(lane_act),
    .port_present(port_present), .cfg_lamp_test(cfg_lamp_test),
    .port_link_up(lo_link), .port_led_act(lo_act),
    .port_led_stat_r(lo_r), .port_led_stat_g(lo_g),
    .port_led_stat_b(lo_b), .port_led_stat_y(lo_y)
  );

  // Reference model state, all expressed in ms-tick timestamps.
  int   cycSinceRst;
  int   ticks;
  int   chgTick [PC];
  int   actTick [PC];
  int   lampTick;
  logic [LC-1:0] prevStatus [PC];
  int   pState  [PC];
  int   nState  [PC];
  bit   modelValid = 1'b0;
  bit   tickNow;
  bit   phase;
  int   step;
  int   holdLeft;
  int   newTicks;
  logic [LC-1:0] curStatus;
  logic [PC-1:0] expLink, expAct, expR, expG, expB, expY;

  // Reference model, evaluated at each rising edge using pre-edge values.
  always @(posedge clk) begin
    if (rst) begin
      cycSinceRst = 0;
      ticks       = 0;
      lampTick    = 0;
      for (int p = 0; p < PC; p++) begin
        chgTick[p]    = 0;
        actTick[p]    = -1000;
        prevStatus[p] = '0;
        pState[p]     = M_ABSENT;
      end
      expLink = '0; expAct = '0; expR = '0; expG = '0; expB = '0; expY = '0;
      modelValid = 1'b1;
    end else begin
      tickNow = ((cycSinceRst % TICK_CYC) == TICK_CYC - 1);
      phase   = (((ticks / HALF) % 2) == 0);
      step    = ((ticks - lampTick) / HALF) % 4;
      for (int p = 0; p < PC; p++) begin
        holdLeft = ACT_MS - (ticks - actTick[p]);
        if (holdLeft < 0) holdLeft = 0;
        expLink[p] = (pState[p] == M_LINK_UP);
        expR[p] = 1'b0; expG[p] = 1'b0; expB[p] = 1'b0; expY[p] = 1'b0;
        if (cfg_lamp_test) begin
          expAct[p] = phase;
          expR[p] = (step == 0); expG[p] = (step == 1);
          expB[p] = (step == 2); expY[p] = (step == 3);
        end else begin
          expAct[p] = (holdLeft > 0) ? phase : (pState[p] == M_LINK_UP);
          if (pState[p] == M_NO_LINK) expY[p] = phase;
          if (pState[p] == M_PARTIAL) expY[p] = 1'b1;
          if (pState[p] == M_LINK_UP) expG[p] = 1'b1;
        end
        nState[p] = pState[p];
        if (!port_present[p]) nState[p] = M_ABSENT;
        else if (pState[p] == M_ABSENT) nState[p] = M_NO_LINK;
        else if ((ticks - chgTick[p]) >= DEB_MS) begin
          if (prevStatus[p] == '1) nState[p] = M_LINK_UP;
          else if (prevStatus[p] != '0) nState[p] = M_PARTIAL;
          else nState[p] = M_NO_LINK;
        end
      end
      newTicks = ticks + (tickNow ? 1 : 0);
      for (int p = 0; p < PC; p++) begin
        curStatus = lane_rx_status[p*LC +: LC];
        if (curStatus != prevStatus[p]) chgTick[p] = newTicks;
        prevStatus[p] = curStatus;
        if (lane_act[p*LC +: LC] != '0) actTick[p] = newTicks;
        pState[p] = nState[p];
      end
      if (!cfg_lamp_test) lampTick = newTicks;
      ticks = newTicks;
      cycSinceRst++;
    end
  end

  task automatic checkOutput(input string tag, input logic [PC-1:0] got,
                             input logic [PC-1:0] want);
    testCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s got=%b want=%b at %0t", tag, got, want, $time);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("hi_link_up", hi_link, expLink);
      checkOutput("hi_led_act", hi_act,  expAct);
      checkOutput("hi_led_r",   hi_r,    expR);
      checkOutput("hi_led_g",   hi_g,    expG);
      checkOutput("hi_led_b",   hi_b,    expB);
      checkOutput("hi_led_y",   hi_y,    expY);
      checkOutput("lo_link_up", lo_link, expLink);
      checkOutput("lo_led_act", lo_act,  ~expAct);
      checkOutput("lo_led_r",   lo_r,    ~expR);
      checkOutput("lo_led_g",   lo_g,    ~expG);
      checkOutput("lo_led_b",   lo_b,    ~expB);
      checkOutput("lo_led_y",   lo_y,    ~expY);
    end
  end

  task automatic applyStimulus(input logic rs, input logic [PC*LC-1:0] rxs,
                               input logic [PC*LC-1:0] act,
                               input logic [PC-1:0] pres, input logic lamp);
    @(posedge clk);
    #2;
    rst            = rs;
    lane_rx_status = rxs;
    lane_act       = act;
    port_present   = pres;
    cfg_lamp_test  = lamp;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      lane_act = '0;
    end
  endtask

  logic [PC*LC-1:0] rxCur;
  logic [PC*LC-1:0] actCur;
  logic [PC-1:0]    presCur;
  logic             lampCur;
  logic             rstCur;
  int               pick;

  initial begin
    rst = 1'b1; lane_rx_status = '0; lane_act = '0; port_present = '0;
    cfg_lamp_test = 1'b0;
    $display("[TB] start");
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    idle(100);

    // Port 0 comes up with all lanes; port 1 stays empty.
    applyStimulus(1'b0, 8'h0F, '0, 2'b01, 1'b0); idle(200);
    // Short bounce on lane 2, then a long drop.
    applyStimulus(1'b0, 8'h0B, '0, 2'b01, 1'b0); idle(4);
    applyStimulus(1'b0, 8'h0F, '0, 2'b01, 1'b0); idle(60);
    applyStimulus(1'b0, 8'h0B, '0, 2'b01, 1'b0); idle(60);
    applyStimulus(1'b0, 8'h0F, '0, 2'b01, 1'b0); idle(60);
    // Single activity pulse, then a steady pulse train.
    applyStimulus(1'b0, 8'h0F, 8'h01, 2'b01, 1'b0); idle(80);
    repeat (20) begin
      applyStimulus(1'b0, 8'h0F, 8'h04, 2'b01, 1'b0); idle(9);
    end
    idle(60);
    // Module removal and reinsertion.
    applyStimulus(1'b0, 8'h0F, '0, 2'b00, 1'b0); idle(20);
    applyStimulus(1'b0, 8'hF3, '0, 2'b11, 1'b0); idle(80);
    // Lamp test with both ports populated.
    applyStimulus(1'b0, 8'hF3, '0, 2'b11, 1'b1); idle(150);
    applyStimulus(1'b0, 8'hF3, '0, 2'b11, 1'b0); idle(40);
    // Mid-operation reset.
    applyStimulus(1'b1, 8'hF3, '0, 2'b11, 1'b0); idle(3);
    applyStimulus(1'b0, 8'hF3, '0, 2'b11, 1'b0); idle(60);

    // Randomised operation.
    rxCur = 8'hF3; presCur = 2'b11; lampCur = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) begin
        pick = $urandom_range(0, PC - 1);
        case ($urandom_range(0, 2))
          0:       rxCur[pick*LC +: LC] = '0;
          1:       rxCur[pick*LC +: LC] = '1;
          default: rxCur[pick*LC +: LC] = LC'($urandom);
        endcase
      end
      actCur = '0;
      if ($urandom_range(0, 15) == 0) actCur = (PC*LC)'($urandom);
      if ($urandom_range(0, 299) == 0) presCur[$urandom_range(0, PC - 1)] ^= 1'b1;
      if ($urandom_range(0, 399) == 0) lampCur = ~lampCur;
      rstCur = ($urandom_range(0, 1499) == 0);
      applyStimulus(rstCur, rxCur, actCur, presCur, lampCur);
    end
    applyStimulus(1'b0, rxCur, '0, presCur, 1'b0); idle(20);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
